// File: rtl/sram_req_ctrl_pkg.sv
// Shared types, default widths and helpers for the SRAM request controller.
// Imported by the interface, the response FIFO and the top level.
package sram_pkg;

  localparam int SRAM_AW = 2;
  localparam int SRAM_DW = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Observability bundle; occupancy is zero-extended to a fixed width.
  typedef struct packed {
    ctrl_state_e state;
    logic [1:0]  inflight;
    logic [7:0]  fifo_occ;
    logic        fifo_full;
    logic        fifo_empty;
  } ctrl_dbg_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request, response and SRAM pin bundle for sram_req_ctrl.
// Handshakes: a transfer happens on a rising edge where valid && ready; a
// producer holds valid and its payload until that edge.
interface sram_req_ctrl_if
  import sram_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  logic          init_done;

  logic          sram_nWE;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_d_in;
  logic [DW-1:0] sram_d_out;

  ctrl_dbg_t     dbg;

  modport slave (
    input  req_valid, req_we, req_adr, req_wdata, rsp_ready, sram_d_out,
    output req_ready, rsp_valid, rsp_data, init_done,
    output sram_nWE, sram_adr, sram_d_in, dbg
  );

  modport master (
    output req_valid, req_we, req_adr, req_wdata, rsp_ready, sram_d_out,
    input  req_ready, rsp_valid, rsp_data, init_done,
    input  sram_nWE, sram_adr, sram_d_in, dbg
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO with a registered head (valid/data) so the
// consumer-facing outputs come straight from flops.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int DW        = SRAM_DW,
  parameter int RSP_DEPTH = 4,
  localparam int PW = (clog2(RSP_DEPTH) > 0) ? clog2(RSP_DEPTH) : 1,
  localparam int OW = clog2(RSP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic [OW-1:0] occ_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [RSP_DEPTH];
  logic [DW-1:0] mem_d [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pop      = pop_i && valid_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    // Head is taken from the post-update array so a push into an empty
    // (or emptying) FIFO is visible on the very next cycle.
    valid_d = (occ_d != '0);
    data_d  = valid_d ? mem_d[rd_ptr_d] : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = data_q;
  assign occ_o      = occ_q;
  assign full_o     = (occ_q == OW'(RSP_DEPTH));
  assign empty_o    = (occ_q == '0);

endmodule

// File: rtl/sram_req_ctrl.sv
// Front-end for a single-port synchronous SRAM: clears the array after reset,
// then serves valid/ready reads and writes with credit-protected responses.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int AW        = SRAM_AW,
  parameter int DW        = SRAM_DW,
  parameter int RSP_DEPTH = 4
) (
  input  logic           clk,
  input  logic           nRST,
  sram_req_ctrl_if.slave bus
);

  localparam int CW = clog2(RSP_DEPTH + 1);

  ctrl_state_e   state_q, state_d;
  logic [AW:0]   init_cnt_q, init_cnt_d;
  logic          nwe_q, nwe_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] din_q, din_d;
  logic          p1_q, p1_d;
  logic          p2_q, p2_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          ready_q, ready_d;
  logic          init_done_q, init_done_d;

  logic          accept;
  logic          rd_accept;
  logic          pop;
  logic [CW-1:0] fifo_occ;
  logic          fifo_full;
  logic          fifo_empty;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    nwe_d       = 1'b1;
    adr_d       = adr_q;
    din_d       = din_q;
    p1_d        = 1'b0;
    p2_d        = p1_q;
    init_done_d = init_done_q;

    accept    = bus.req_valid && ready_q;
    rd_accept = accept && !bus.req_we;
    pop       = bus.rsp_valid && bus.rsp_ready;

    case (state_q)
      INIT: begin
        // The extra counter bit marks that the last address has been written.
        if (init_cnt_q[AW]) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          nwe_d      = 1'b0;
          adr_d      = init_cnt_q[AW-1:0];
          din_d      = '0;
          init_cnt_d = init_cnt_q + {{AW{1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (accept) begin
          adr_d = bus.req_adr;
          if (bus.req_we) begin
            nwe_d = 1'b0;
            din_d = bus.req_wdata;
          end else begin
            p1_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase

    // Credits count reads in the pipeline plus FIFO entries; a push only
    // moves a read from the pipeline into the FIFO, so it is neutral here.
    credits_d = credits_q + CW'(rd_accept) - CW'(pop);
    ready_d   = (state_d == RUN) && (credits_d < CW'(RSP_DEPTH));
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      nwe_q       <= 1'b1;
      adr_q       <= '0;
      din_q       <= '0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      credits_q   <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      nwe_q       <= nwe_d;
      adr_q       <= adr_d;
      din_q       <= din_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      credits_q   <= credits_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  sram_rsp_fifo #(
    .DW        (DW),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (nRST),
    .push_i      (p2_q),
    .push_data_i (bus.sram_d_out),
    .pop_i       (pop),
    .rd_valid_o  (bus.rsp_valid),
    .rd_data_o   (bus.rsp_data),
    .occ_o       (fifo_occ),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.req_ready = ready_q;
  assign bus.init_done = init_done_q;
  assign bus.sram_nWE  = nwe_q;
  assign bus.sram_adr  = adr_q;
  assign bus.sram_d_in = din_q;

  always_comb begin
    bus.dbg            = '0;
    bus.dbg.state      = state_q;
    bus.dbg.inflight   = {1'b0, p1_q} + {1'b0, p2_q};
    bus.dbg.fifo_occ   = 8'(fifo_occ);
    bus.dbg.fifo_full  = fifo_full;
    bus.dbg.fifo_empty = fifo_empty;
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl with a behavioural SRAM macro,
// a reference memory model and an in-order response scoreboard.
module tb_sram_req_ctrl;
  import sram_pkg::*;

  localparam int AW        = 2;
  localparam int DW        = 2;
  localparam int RSP_DEPTH = 4;
  localparam int N         = 1 << AW;

  logic clk  = 1'b0;
  logic nRST = 1'b1;

  int n_cmp   = 0;
  int n_err   = 0;
  int max_occ = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [N];
  logic [DW-1:0] sram_mem [N];
  logic          send_done;

  sram_req_ctrl_if #(.AW(AW), .DW(DW)) bus();

  sram_req_ctrl #(
    .AW        (AW),
    .DW        (DW),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // SRAM macro: write commits on the edge, read data registered on the edge
  always @(posedge clk) begin
    if (!bus.sram_nWE) sram_mem[bus.sram_adr] <= bus.sram_d_in;
    else               bus.sram_d_out <= sram_mem[bus.sram_adr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: compare the head whenever it will be taken at the next edge
  always @(negedge clk) begin
    if (nRST && bus.rsp_valid && bus.rsp_ready) begin
      check("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
    end
    if (int'(bus.dbg.fifo_occ) > max_occ) max_occ = int'(bus.dbg.fifo_occ);
  end

  // driver tasks: all drive changes happen #1 after a rising edge
  task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] data);
    int   waited;
    logic acc;
    waited = 0;
    acc    = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_wdata = data;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    check("req_accept", 32'(acc), 32'd1);
    if (acc) begin
      if (we) model[adr] = data;
      else    exp_q.push_back(model[adr]);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_adr    = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus.sram_d_out = '0;
    send_done      = 1'b0;
    clear_model();

    // reset values
    #1 nRST = 1'b0;
    #1;
    check("rst_nWE",       32'(bus.sram_nWE),  32'd1);
    check("rst_adr",       32'(bus.sram_adr),  32'd0);
    check("rst_d_in",      32'(bus.sram_d_in), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);

    // array clear sequence
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("init_nWE",   32'(bus.sram_nWE),  32'd0);
      check("init_adr",   32'(bus.sram_adr),  32'(i));
      check("init_d_in",  32'(bus.sram_d_in), 32'd0);
      check("init_ready", 32'(bus.req_ready), 32'd0);
      check("init_done0", 32'(bus.init_done), 32'd0);
    end
    @(negedge clk);
    check("run_nWE",       32'(bus.sram_nWE),  32'd1);
    check("run_init_done", 32'(bus.init_done), 32'd1);
    check("run_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) send(1'b0, AW'(i), '0);
    wait_drain();

    // write then read the same address on the next cycle
    bus.rsp_ready = 1'b0;
    send(1'b1, 2'd2, 2'd3);
    send(1'b0, 2'd2, 2'd0);
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("read_latency", 32'(lat), 32'd2);
    check("raw_data",     32'(bus.rsp_data), 32'd3);
    bus.rsp_ready = 1'b1;
    wait_drain();

    // fill pattern, then four reads under backpressure
    for (int i = 0; i < N; i++) send(1'b1, AW'(i), DW'(i + 1));
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) send(1'b0, AW'(i), '0);
    check("bp_ready_low", 32'(bus.req_ready), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("bp_occ_full",  32'(bus.dbg.fifo_occ), 32'd4);
    check("bp_head",      32'(bus.rsp_data),     32'd1);
    check("bp_ready_hold", 32'(bus.req_ready),   32'd0);
    bus.rsp_ready = 1'b1;
    wait_drain();
    check("bp_ready_back", 32'(bus.req_ready), 32'd1);

    // mixed traffic with the consumer toggling every cycle
    max_occ = 0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          if ($urandom_range(0, 3) == 0) send(1'b1, AW'($urandom_range(0, N - 1)), DW'($urandom_range(0, 3)));
          else                           send(1'b0, AW'($urandom_range(0, N - 1)), '0);
        end
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = ~bus.rsp_ready;
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_drain();
    check("occ_bound", 32'(max_occ <= RSP_DEPTH), 32'd1);

    // reset with two reads in flight and two responses queued
    bus.rsp_ready = 1'b0;
    send(1'b0, 2'd3, '0);
    send(1'b0, 2'd2, '0);
    send(1'b0, 2'd1, '0);
    send(1'b0, 2'd3, '0);
    check("pre_rst_occ",      32'(bus.dbg.fifo_occ), 32'd2);
    check("pre_rst_inflight", 32'(bus.dbg.inflight), 32'd2);
    #2 nRST = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("arst_req_ready", 32'(bus.req_ready), 32'd0);
    check("arst_init_done", 32'(bus.init_done), 32'd0);
    check("arst_nWE",       32'(bus.sram_nWE),  32'd1);
    check("arst_adr",       32'(bus.sram_adr),  32'd0);
    check("arst_d_in",      32'(bus.sram_d_in), 32'd0);
    exp_q.delete();
    clear_model();
    bus.rsp_ready = 1'b1;

    // request held during INIT must wait for RUN
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_adr   = 2'd1;
    bus.req_wdata = 2'd3;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("reinit_nWE",   32'(bus.sram_nWE),  32'd0);
      check("reinit_adr",   32'(bus.sram_adr),  32'(i));
      check("reinit_d_in",  32'(bus.sram_d_in), 32'd0);
      check("reinit_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    check("rerun_nWE",   32'(bus.sram_nWE),  32'd1);
    check("rerun_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("held_wr_nWE",  32'(bus.sram_nWE),  32'd0);
    check("held_wr_adr",  32'(bus.sram_adr),  32'd1);
    check("held_wr_d_in", 32'(bus.sram_d_in), 32'd3);
    model[1] = 2'd3;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) send(1'b0, AW'(i), '0);
    wait_drain();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request/response front-end that sits directly upstream of the single-port synchronous SRAM macro and drives its clk-domain pins: `nWE`, `adr`, `d_in`. It consumes the macro's registered `d_out`.
- After reset it clears the whole array to zero. It then accepts valid/ready read and write requests and returns read data in order through a small response FIFO with backpressure.
- A credit count ensures no read data is ever dropped.

Parameters:
- AW, 2, address width; must match the SRAM macro.
- DW, 2, data width; must match the SRAM macro.
- RSP_DEPTH, 4, response FIFO entries, minimum 1. A value of 3 or more is needed for back-to-back read throughput.

Ports:
- clk  in  1  single clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where valid && ready.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  AW  request address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes data on an edge where valid && ready.
- rsp_data  out  DW  read data, FIFO head.
- init_done  out  1  array clear complete.
- sram_nWE  out  1  to macro nWE; 0 = write.
- sram_adr  out  AW  to macro adr.
- sram_d_in  out  DW  to macro d_in.
- sram_d_out  in  DW  from macro d_out.

Behaviour:
- Clock and reset: one clock, `clk`; reset `nRST` is asynchronous, active-low.
- All outputs and pin signals are registered.
- Reset values:
  - sram_nWE=1, sram_adr=0, sram_d_in=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, init_done=0.
  - FSM in INIT, init counter 0, FIFO empty, read pipeline flags clear.
- FSM INIT:
  - On each edge, load the pins with a write of 0 to the address given by the init counter, then increment the counter.
  - Counter runs 0 .. 2^AW-1; no wrap is used.
  - On the edge after the pins carry address 2^AW-1: pins return to idle (nWE=1), FSM goes to RUN, init_done=1.
  - req_ready=0 throughout INIT.
- FSM RUN:
  - init_done stays 1 until reset.
  - The only exit is reset. Reset mid-operation discards in-flight reads and FIFO contents, returns to INIT and re-clears the array.
- Idle pins:
  - nWE=1; adr and d_in hold their last value.
  - Idle reads by the macro are ignored because no pipeline flag is set.
- Credits:
  - inflight = number of set read pipeline flags (0..2).
  - occ = FIFO occupancy.
  - req_ready = RUN && (inflight + occ < RSP_DEPTH).
  - req_ready does not depend on req_we or req_valid.
  - The credit counter width is clog2(RSP_DEPTH+1).
- Accepted write at edge E:
  - Pins get nWE=0, adr, d_in.
  - The macro commits the write at E+1.
  - No response is produced.
- Accepted read at edge E:
  - Pins get nWE=1 and adr; flag p1 is set.
  - At E+1 the macro registers d_out, and p2 <= p1.
  - At E+2 sram_d_out is pushed into the FIFO, and rsp_valid is visible after E+2.
  - Read latency is 2 cycles from the accept edge.
  - The macro's internal output delay must be shorter than the clock period.
- Ordering:
  - A read accepted at E+1 after a write to the same address at E returns the new data; no hazard logic is needed.
  - Responses are returned strictly in request order.
- FIFO:
  - Push and pop may occur on the same edge; occ is then unchanged, including when full or when occ=1.
  - The credit rule makes overflow impossible.
  - Pop on empty is impossible because rsp_valid=0.
  - Read and write pointers wrap modulo RSP_DEPTH.
  - rsp_data and rsp_valid are held stable while rsp_ready=0.
- Back-to-back requests: one request per cycle when credits allow.

Decomposition:
- Shared package `sram_pkg`:
  - FSM state enum {INIT, RUN}.
  - Default AW and DW.
  - Function clog2.
- One sub-module: `sram_rsp_fifo`, the parameterised synchronous FIFO (DW, RSP_DEPTH) with push, pop, occ, full and empty outputs.
- The FSM, credit logic and pin registers stay in the top level.

Test Plan (AW=2, DW=2, RSP_DEPTH=4):
- Release nRST, no requests:
  - Pins show writes of 0 to addresses 0,1,2,3 on 4 consecutive cycles.
  - init_done and req_ready then rise; reads of addresses 0..3 all return 0.
- Write adr2=3, next cycle read adr2:
  - rsp_valid is seen 2 cycles after the read accept, with rsp_data=3.
- Fill the array with the data pattern {1,2,3,0}, then issue 4 back-to-back reads with rsp_ready=0:
  - req_ready drops after the 4th accept; the FIFO holds 1,2,3,0.
  - Raise rsp_ready: data drains in order and req_ready reasserts.
- Continuous reads with rsp_ready toggling every cycle:
  - No loss or duplication, in-order data, occ never exceeds 4.
- Assert nRST mid-stream with 2 reads in flight and 2 entries in the FIFO:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - On release, INIT re-clears the array and no stale responses appear.
- Request during INIT with req_valid=1:
  - Not accepted; pins show only init writes; the request is accepted on the first cycle in RUN.
